fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction prefetch queue that sits between instruction fetch (PC register, PC+4 adder, instruction memory) and the control/decode stage.
- Buffers up to DEPTH {pc, inst} pairs so fetch can run ahead of decode.
- Discards all buffered entries when decode redirects the PC (J/JAL/JR/taken branch).
- Detects the all-zero end-of-program word and stops accepting further fetches.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- CNT_W, 3, width of count output; must equal log2(DEPTH)+1.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  fetch presents a valid pc/inst pair
- in_ready  output  1  queue accepts the pair this cycle
- in_pc  input  32  PC of the fetched word
- in_inst  input  32  fetched instruction word
- flush  input  1  redirect from decode; discard all entries
- out_valid  output  1  head entry is valid
- out_ready  input  1  decode consumes the head this cycle
- out_pc  output  32  PC of head entry
- out_inst  output  32  instruction of head entry
- out_pcplus4  output  32  out_pc + 4, modulo 2^32
- count  output  CNT_W  number of occupied entries (0..DEPTH)
- halted  output  1  end-of-program word has been enqueued

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low (reset_n). All state changes on the rising edge of clock.
- Reset values:
  - count=0, out_valid=0, halted=0.
  - Read and write pointers = 0.
  - out_pc=0, out_inst=0, out_pcplus4=4.
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards everything immediately, without waiting for a clock edge.
- Storage: DEPTH-entry circular buffer of 64-bit {pc, inst}. Write and read pointers wrap modulo DEPTH.
- in_ready = (count != DEPTH) && !halted. Purely a function of registered state; it does not look ahead to a same-cycle pop.
- Push occurs on a clock edge when in_valid && in_ready && !flush:
  - Entry is written at the write pointer; the write pointer increments.
  - If in_inst == 32'h00000000, halted is set to 1 on the same edge. The zero word itself is enqueued.
- out_valid = (count != 0).
- out_pc and out_inst are a combinational read of the entry at the read pointer, forced to 0 when count == 0.
- out_pcplus4 = out_pc + 32'd4, with 32-bit wrap-around.
- Pop occurs on a clock edge when out_valid && out_ready && !flush. The read pointer increments.
- Simultaneous push and pop in the same edge: count is unchanged and both pointers advance. This is legal at any count where in_ready is high.
- Count update: count_next = count + push - pop. It never exceeds DEPTH and never goes below 0.
- Pop while empty is ignored (out_ready with out_valid=0 has no effect). Push while in_ready=0 is ignored and the data is dropped; fetch must hold its values.
- Flush on a clock edge:
  - Both pointers and count go to 0, and halted clears.
  - Flush has priority over any same-edge push or pop; the word presented that cycle is not enqueued.
  - out_valid is 0 in the cycle after flush.
- Halted state:
  - Enqueueing stops, but entries already queued (including the zero word) still drain normally through out_ready.
  - Only flush or reset clears halted.
- Latency: a word pushed into an empty queue appears on out_* in the next cycle (1-cycle fall-through). There is no bypass in the push cycle.
- Ordering: strict FIFO; there is no reordering and no duplication.

Test Plan:
- Reset check: hold reset_n=0 and toggle clock. Release reset, then push pc=0x00400000 inst=0x20080005 with out_ready=0. Required: out_valid=1 next cycle, out_pc=0x00400000, out_pcplus4=0x00400004, count=1.
- Fill: push 4 words at pc 0x00400000..0x0040000C with out_ready=0. Required: count=4, in_ready=0. A 5th push (pc 0x00400010) is ignored. Draining then yields exactly the 4 PCs in order and the pointers wrap.
- Streaming: in_valid=1 and out_ready=1 continuously with count=2. Required: count stays 2 and out_pc advances by 4 every cycle.
- Flush: with count=3, assert flush together with in_valid=1 (pc 0x00400020). Required: next cycle count=0 and out_valid=0. Entry 0x00400020 is not queued. A following push of pc 0x00400040 appears at the head.
- End of program: push inst 0x08100003 then inst 0x00000000. Required: halted=1 and in_ready=0 after the second push. Both words drain in order. Flush clears halted and sets in_ready=1.
- Async reset mid-stream: drop reset_n between clock edges with count=3. Required: count=0, out_valid=0 and out_pc=0 immediately, before the next rising edge.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bus: enqueue handshake, dequeue handshake, flush and status.
// Latency: none, signal bundle only.
// Backpressure: in_ready gates the fetch side, out_ready gates the decode side.
interface fetch_queue_if #(
  parameter int CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_inst;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_inst;
  logic [31:0]      out_pcplus4;
  logic [CNT_W-1:0] count;
  logic             halted;

  // Fetch/decode side: drives pushes, pops and redirects.
  modport master (
    output in_valid, in_pc, in_inst, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_pcplus4, count, halted
  );

  // Queue side.
  modport slave (
    input  in_valid, in_pc, in_inst, flush, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_pcplus4, count, halted
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue of {pc, inst} pairs between fetch and decode; flush on redirect, halts on the zero word.
// Latency: 1 cycle fall-through from push to head, no same-cycle bypass.
// Backpressure: in_ready drops when full or halted; head holds until out_ready.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  fetch_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               halt;
  logic               push;
  logic               pop;
  entry_t             head;

  // Ready depends only on registered state so fetch sees a stable answer all cycle.
  assign bus.in_ready  = (cnt != CNT_W'(DEPTH)) && !halt;
  assign bus.out_valid = (cnt != '0);

  // Flush overrides both handshakes; nothing moves on a redirect edge.
  assign push = bus.in_valid  && bus.in_ready  && !bus.flush;
  assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

  // Head is forced to zero when empty so decode never sees stale storage.
  always_comb begin
    head = '0;
    if (cnt != '0) head = mem[rd_ptr];
  end

  assign bus.out_pc      = head.pc;
  assign bus.out_inst    = head.inst;
  assign bus.out_pcplus4 = head.pc + 32'd4;
  assign bus.count       = cnt;
  assign bus.halted      = halt;

  // Storage carries no reset; occupancy is tracked by cnt alone.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{pc: bus.in_pc, inst: bus.in_inst};
  end

  // Pointers, occupancy and halt flag; flush returns everything to the empty state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      halt   <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      halt   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (bus.in_inst == 32'h0000_0000) halt <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill, streaming, flush, end-of-program, async reset.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Expected values are hand-computed constants.
module tb_fetch_queue;
  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  fetch_queue_if #(.CNT_W(3)) bus ();

  fetch_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_inst  = inst;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_inst   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // ---- reset ----
    repeat (3) step();
    chk("rst_count",   32'(bus.count),  32'd0);
    chk("rst_ovalid",  32'(bus.out_valid), 32'd0);
    chk("rst_halted",  32'(bus.halted), 32'd0);
    chk("rst_opc",     bus.out_pc,      32'h0);
    chk("rst_oinst",   bus.out_inst,    32'h0);
    chk("rst_pcplus4", bus.out_pcplus4, 32'h4);
    #2 reset_n = 1'b1;
    step();
    chk("rst_iready",  32'(bus.in_ready), 32'd1);

    // ---- first push, 1-cycle fall-through ----
    push_one(32'h0040_0000, 32'h2008_0005);
    chk("p1_ovalid",  32'(bus.out_valid), 32'd1);
    chk("p1_opc",     bus.out_pc,      32'h0040_0000);
    chk("p1_oinst",   bus.out_inst,    32'h2008_0005);
    chk("p1_pcplus4", bus.out_pcplus4, 32'h0040_0004);
    chk("p1_count",   32'(bus.count),  32'd1);

    // ---- fill to DEPTH, overflow push dropped ----
    for (int i = 1; i < 4; i++) push_one(32'h0040_0000 + 32'(4 * i), 32'h2008_0000 + 32'(i));
    chk("fill_count",  32'(bus.count), 32'd4);
    chk("fill_iready", 32'(bus.in_ready), 32'd0);
    push_one(32'h0040_0010, 32'h2008_0010);
    chk("ovf_count",   32'(bus.count), 32'd4);
    chk("ovf_head",    bus.out_pc, 32'h0040_0000);

    // ---- drain in order ----
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", bus.out_pc, 32'h0040_0000 + 32'(4 * i));
      step();
    end
    bus.out_ready = 1'b0;
    chk("drain_count",  32'(bus.count), 32'd0);
    chk("drain_ovalid", 32'(bus.out_valid), 32'd0);
    chk("drain_opc",    bus.out_pc, 32'h0);

    // ---- streaming at count=2, pointers already wrapped ----
    push_one(32'h0040_0100, 32'h0000_1100);
    push_one(32'h0040_0104, 32'h0000_1104);
    chk("strm_pre", 32'(bus.count), 32'd2);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.in_pc   = 32'h0040_0108 + 32'(4 * k);
      bus.in_inst = 32'h0000_1108 + 32'(4 * k);
      step();
      chk("strm_count", 32'(bus.count), 32'd2);
      chk("strm_pc",    bus.out_pc, 32'h0040_0104 + 32'(4 * k));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("strm_inst", bus.out_inst, 32'h0000_1118);

    // ---- flush with count=3 beats a same-edge push ----
    push_one(32'h0040_0300, 32'h0000_3300);
    chk("fl_pre", 32'(bus.count), 32'd3);
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_pc     = 32'h0040_0020;
    bus.in_inst   = 32'h0000_2020;
    step();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("fl_count",  32'(bus.count), 32'd0);
    chk("fl_ovalid", 32'(bus.out_valid), 32'd0);
    push_one(32'h0040_0040, 32'h0000_4040);
    chk("fl_head",   bus.out_pc, 32'h0040_0040);
    chk("fl_count1", 32'(bus.count), 32'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("fl_empty", 32'(bus.count), 32'd0);

    // ---- end of program ----
    push_one(32'h0040_0200, 32'h0810_0003);
    chk("eop_nohalt", 32'(bus.halted), 32'd0);
    push_one(32'h0040_0204, 32'h0000_0000);
    chk("eop_halted", 32'(bus.halted), 32'd1);
    chk("eop_iready", 32'(bus.in_ready), 32'd0);
    chk("eop_count",  32'(bus.count), 32'd2);
    push_one(32'h0040_0208, 32'h0000_0001);
    chk("eop_drop",   32'(bus.count), 32'd2);
    bus.out_ready = 1'b1;
    chk("eop_d0_pc",   bus.out_pc,   32'h0040_0200);
    chk("eop_d0_inst", bus.out_inst, 32'h0810_0003);
    step();
    chk("eop_d1_pc",   bus.out_pc,   32'h0040_0204);
    chk("eop_d1_inst", bus.out_inst, 32'h0000_0000);
    chk("eop_d1_vld",  32'(bus.out_valid), 32'd1);
    step();
    bus.out_ready = 1'b0;
    chk("eop_drained", 32'(bus.count), 32'd0);
    chk("eop_stick",   32'(bus.halted), 32'd1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("eop_fl_halt",  32'(bus.halted), 32'd0);
    chk("eop_fl_ready", 32'(bus.in_ready), 32'd1);

    // ---- asynchronous reset between edges ----
    push_one(32'h0040_0500, 32'h0000_5500);
    push_one(32'h0040_0504, 32'h0000_5504);
    push_one(32'h0040_0508, 32'h0000_5508);
    chk("ar_pre", 32'(bus.count), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_count",  32'(bus.count), 32'd0);
    chk("ar_ovalid", 32'(bus.out_valid), 32'd0);
    chk("ar_opc",    bus.out_pc, 32'h0);
    #3 reset_n = 1'b1;
    step();
    chk("ar_after", 32'(bus.count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
